// File: rtl/core_alu_operand_fetch.sv
// Operand fetcher: reads a vertex record and a follower x/y from single-port node RAM.
// Optional CORE_ALU_FETCH_SAME_NODE_BYPASS_EN skips the follower reads when v == f.
module core_alu_operand_fetch #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NODE_COUNT = 5,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  v_index,
  input  logic [IDX_W-1:0]  f_index,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  output logic [WIDTH-1:0]  x_position,
  output logic [WIDTH-1:0]  y_position,
  output logic [WIDTH-1:0]  pre_x_position,
  output logic [WIDTH-1:0]  pre_y_position,
  output logic [WIDTH-1:0]  prev_node_x_position,
  output logic [WIDTH-1:0]  prev_node_y_position,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [IDX_W-1:0]   v_q, v_d, f_q, f_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   op_q [6];
  logic [WIDTH-1:0]   op_d [6];
  logic               same_node;
  logic [2:0]         last_k;
  logic               capture;
  logic [2:0]         cap_idx;
  logic               in_range;

`ifdef CORE_ALU_FETCH_SAME_NODE_BYPASS_EN
  assign same_node = (v_q == f_q);
`else
  assign same_node = 1'b0;
`endif

  assign last_k   = same_node ? 3'd3 : 3'd5;
  assign in_range = (32'(v_index) < NODE_COUNT) && (32'(f_index) < NODE_COUNT);

  // Data for read k-1 arrives while read k is issued; DRAIN picks up the last one (k unchanged).
  assign capture = (state_q == StIssue && k_q != 3'd0) || (state_q == StDrain);
  assign cap_idx = (state_q == StDrain) ? k_q : k_q - 3'd1;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] field);
    return ADDR_W'({idx, 2'b00}) + ADDR_W'(field);
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    v_d     = v_q;
    f_d     = f_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    err_d   = err_q;
    for (int i = 0; i < 6; i++) begin
      op_d[i] = op_q[i];
      if (capture && cap_idx == 3'(i)) op_d[i] = ram_rdata;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          v_d = v_index;
          f_d = f_index;
          k_d = 3'd0;
          if (in_range) begin
            err_d   = 1'b0;
            rd_en_d = 1'b1;
            addr_d  = word_addr(v_index, 2'd0);
            state_d = StIssue;
          end else begin
            err_d = 1'b1;
            for (int i = 0; i < 6; i++) op_d[i] = '0;
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (k_q == last_k) begin
          rd_en_d = 1'b0;
          state_d = StDrain;
        end else begin
          k_d    = k_q + 3'd1;
          addr_d = word_addr((k_d < 3'd4) ? v_q : f_q, k_d[1:0]);
        end
      end
      StDrain: begin
        if (same_node) begin
          op_d[4] = op_q[0];
          op_d[5] = op_q[1];
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      v_q     <= '0;
      f_q     <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 6; i++) op_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      v_q     <= v_d;
      f_q     <= f_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      for (int i = 0; i < 6; i++) op_q[i] <= op_d[i];
    end
  end

  assign req_ready            = (state_q == StIdle);
  assign busy                 = (state_q != StIdle);
  assign out_valid            = (state_q == StDone);
  assign out_err              = err_q;
  assign ram_rd_en            = rd_en_q;
  assign ram_addr             = addr_q;
  assign x_position           = op_q[0];
  assign y_position           = op_q[1];
  assign pre_x_position       = op_q[2];
  assign pre_y_position       = op_q[3];
  assign prev_node_x_position = op_q[4];
  assign prev_node_y_position = op_q[5];

endmodule

// File: tb/tb_core_alu_operand_fetch.sv
// Bench for core_alu_operand_fetch: RAM holds word[a] = a + 100, directed plus random fetches.
module tb_core_alu_operand_fetch;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned NODE_COUNT = 5;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned ADDR_W     = 5;
`ifdef CORE_ALU_FETCH_SAME_NODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, ram_rd_en, out_valid, out_ready, out_err, busy;
  logic [IDX_W-1:0]  v_index, f_index;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_rdata;
  logic [WIDTH-1:0]  x_position, y_position, pre_x_position, pre_y_position;
  logic [WIDTH-1:0]  prev_node_x_position, prev_node_y_position;
  logic [WIDTH-1:0]  obs [6];

  int n_assert = 0;
  int n_fail   = 0;
  int addr_log [$];

  core_alu_operand_fetch #(
    .WIDTH(WIDTH), .NODE_COUNT(NODE_COUNT), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .v_index(v_index), .f_index(f_index), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .x_position(x_position), .y_position(y_position), .pre_x_position(pre_x_position),
    .pre_y_position(pre_y_position), .prev_node_x_position(prev_node_x_position),
    .prev_node_y_position(prev_node_y_position), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rdata <= WIDTH'(ram_addr) + 32'd100;
      addr_log.push_back(int'(ram_addr));
    end
  end

  always_comb begin
    obs[0] = x_position;
    obs[1] = y_position;
    obs[2] = pre_x_position;
    obs[3] = pre_y_position;
    obs[4] = prev_node_x_position;
    obs[5] = prev_node_y_position;
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [WIDTH-1:0] exp_op [6]);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_op%0d", tag, i), 64'(obs[i]), 64'(exp_op[i]));
  endtask

  // Reference: record of node n occupies words 4n..4n+3, each holding address + 100.
  task automatic fetch(input int v, input int f, input int stall);
    logic [WIDTH-1:0] exp_op [6];
    int exp_addr [$];
    bit err, same;
    int exp_lat, lat;
    err  = (v >= NODE_COUNT) || (f >= NODE_COUNT);
    same = BYPASS && (v == f) && !err;
    exp_addr.delete();
    if (!err) begin
      for (int i = 0; i < 4; i++) exp_addr.push_back(4 * v + i);
      if (!same) begin
        exp_addr.push_back(4 * f);
        exp_addr.push_back(4 * f + 1);
      end
    end
    for (int i = 0; i < 6; i++)
      exp_op[i] = err ? '0 : WIDTH'((i < 4) ? 4 * v + i + 100 : 4 * f + (i - 4) + 100);
    exp_lat = err ? 1 : (same ? 6 : 8);

    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    addr_log.delete();
    req_valid = 1'b1;
    v_index   = IDX_W'(v);
    f_index   = IDX_W'(f);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    v_index   = IDX_W'($urandom_range(0, 7));
    f_index   = IDX_W'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency_v%0d_f%0d", v, f), 64'(lat), 64'(exp_lat));
    chk("out_err", 64'(out_err), 64'(err));
    chk("busy_done", 64'(busy), 64'd1);
    chk("n_reads", 64'(addr_log.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
      chk($sformatf("ram_addr%0d", i), 64'(addr_log[i]), 64'(exp_addr[i]));
    chk_bundle("bundle", exp_op);
    for (int s = 0; s < stall; s++) begin
      chk("req_ready_stall", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("out_valid_held", 64'(out_valid), 64'd1);
      chk("out_err_held", 64'(out_err), 64'(err));
      chk_bundle("stall", exp_op);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    chk("req_ready_after_hs", 64'(req_ready), 64'd1);
    chk("n_reads_after_hs", 64'(addr_log.size()), 64'(exp_addr.size()));
    chk_bundle("retain", exp_op);
  endtask

  initial begin
    logic [WIDTH-1:0] zero_op [6];
    for (int i = 0; i < 6; i++) zero_op[i] = '0;
    reset     = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    v_index   = '0;
    f_index   = '0;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(ram_rd_en), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk_bundle("rst", zero_op);
    @(negedge clk);
    reset = 1'b0;

    fetch(2, 4, 0);
    fetch(2, 4, 5);
    fetch(5, 0, 2);
    fetch(1, 1, 1);
    fetch(3, 7, 0);

    // Reset during a fetch abandons it.
    fetch(3, 2, 0);
    @(negedge clk);
    req_valid = 1'b1;
    v_index   = 3'd4;
    f_index   = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rd_en", 64'(ram_rd_en), 64'd0);
    chk("midrst_addr", 64'(ram_addr), 64'd0);
    chk_bundle("midrst", zero_op);
    @(negedge clk);
    reset = 1'b0;
    fetch(0, 1, 0);

    for (int n = 0; n < 12; n++)
      fetch($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    for (int n = 0; n < 4; n++) begin
      int idx;
      idx = $urandom_range(0, 4);
      fetch(idx, idx, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/core_alu_operand_fetch.md
Name: core_alu_operand_fetch

Overview:
Sequential, parametrised operand fetcher for the core ALU. It accepts binary node indices for a vertex node and a follower node over a valid/ready handshake. It then reads the vertex record (x, y, pre_x, pre_y) and the follower position (x, y) one word per cycle from a single-port node RAM. The six operands are presented as one registered bundle under a valid/ready handshake. It replaces flat, fully combinational selection, so the node table can live in real RAM and grow to any node count.

Parameters:
- WIDTH, 32, data word width.
- NODE_COUNT, 5, number of node records in RAM; each record is 4 consecutive words: x, y, pre_x, pre_y.
- IDX_W, 3, width of the node index inputs; must satisfy 2^IDX_W >= NODE_COUNT.
- ADDR_W, 5, RAM word address width; must satisfy 2^ADDR_W >= 4*NODE_COUNT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  high only in IDLE.
- v_index  in  IDX_W  vertex node index; sampled on accept.
- f_index  in  IDX_W  follower node index; sampled on accept.
- ram_rd_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM word address.
- ram_rdata  in  WIDTH  RAM data, valid one cycle after ram_rd_en.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_err  out  1  index out of range; qualified by out_valid.
- x_position, y_position, pre_x_position, pre_y_position  out  WIDTH each  vertex record.
- prev_node_x_position, prev_node_y_position  out  WIDTH each  follower x, y.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, except req_ready = 1.
  - FSM goes to IDLE; read counter clears.
  - A reset mid-fetch abandons the transaction; no partial bundle is ever presented.
- Accept: req_valid && req_ready at a rising edge. v_index and f_index are latched internally; later input changes are ignored.
- Range check at accept: if v_index >= NODE_COUNT or f_index >= NODE_COUNT, go to DONE next cycle.
  - No RAM reads are issued.
  - Operand outputs are 0 and out_err = 1.
- FSM states:
  - IDLE: wait for accept.
  - ISSUE: counter k = 0..5; ram_rd_en = 1.
    - Addresses in order: 4*v+0, 4*v+1, 4*v+2, 4*v+3, 4*f+0, 4*f+1.
    - Each cycle also captures the data returned for read k-1.
  - DRAIN: one cycle with ram_rd_en = 0; captures the data for the final read.
  - DONE: out_valid = 1; return to IDLE when out_ready = 1.
- Capture mapping: read k lands in, in order: x_position, y_position, pre_x_position, pre_y_position, prev_node_x_position, prev_node_y_position.
- Timing: accept at edge T0.
  - ISSUE occupies cycles T0+1 to T0+6.
  - DRAIN occupies cycle T0+7.
  - out_valid rises in cycle T0+8.
  - Error path: out_valid rises in cycle T0+1.
- Address arithmetic: ram_addr = {v, 2'b00} + field, computed at ADDR_W bits. No wrap is possible because the range check passes first.
- ram_addr holds its last value when ram_rd_en = 0. ram_rdata is ignored outside capture cycles.
- Backpressure: while out_valid && !out_ready, all bundle outputs and out_err stay stable.
- After a handshake:
  - Operand outputs retain their values until the next capture overwrites them.
  - out_err clears on the next accept.
- Throughput: req_ready rises the cycle after the out handshake, so there is no accept in the same cycle as out_valid. Minimum request spacing is 9 cycles.
- v_index == f_index is legal. Without bypass, the follower words are re-read from RAM.

Optional Feature:
- Macro: CORE_ALU_FETCH_SAME_NODE_BYPASS_EN.
- Defined: if the latched v == f and the indices are in range, ISSUE performs only reads 0..3.
  - prev_node_x_position and prev_node_y_position are loaded from the captured x and y in DRAIN.
  - out_valid rises at T0+6.
- Undefined: all six reads are always issued, as described above.

Test Plan:
- RAM model: word[a] = a + 100, registered read.
- Normal fetch: v=2, f=4 -> x=108, y=109, pre_x=110, pre_y=111, prev_x=116, prev_y=117; out_valid at T0+8; ram_addr sequence 8, 9, 10, 11, 16, 17.
- Backpressure: same request with out_ready = 0 for 5 cycles -> bundle stable and out_valid held; req_ready = 0 until the cycle after the handshake.
- Out of range: v=5, f=0 -> no ram_rd_en pulses; out_valid at T0+1 with out_err = 1 and all operands 0.
- Reset mid-fetch: assert reset at T0+4 -> outputs 0 immediately, req_ready = 1; a following request v=0, f=1 returns 100, 101, 102, 103, 104, 105.
- Same node: v=f=1 -> prev_x = 104, prev_y = 105.
  - Bypass defined: 4 reads, out_valid at T0+6.
  - Bypass undefined: 6 reads, out_valid at T0+8.
